// File: rtl/pow2_div_pkg.sv
// Shared definitions for the sequential power-of-two signed divider.
// Holds the controller state encoding and the helper that sizes the
// shift-amount field from the operand width.
package pow2_div_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Smallest field width able to hold every legal shift 0..n-1, i.e. ceil(log2(n)).
   // Written out as a loop so it can size a port parameter at elaboration time.
   function automatic int shamt_width(input int n);
      int w;
      w = 0;
      while ((1 << w) < n) begin
         w = w + 1;
      end
      if (w == 0) begin
         w = 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/sra_by_one.sv
// Single-step arithmetic right shift.
// Purely combinational: replicates the sign bit into the MSB and drops the LSB.
// Ports:
//   din         N-bit two's-complement value
//   dout        din shifted right by one, sign-extended
//   shifted_out the bit that falls off the bottom (feeds the remainder sticky)
module sra_by_one #(
   parameter int N = 8
) (
   input  logic [N-1:0] din,
   output logic [N-1:0] dout,
   output logic         shifted_out
);

   assign dout        = {din[N-1], din[N-1:1]};
   assign shifted_out = din[0];

endmodule

// File: rtl/pow2_signed_divider_seq.sv
// Sequential signed divide-by-2^k unit.
// Accepts an N-bit two's-complement operand and a shift amount k, then walks
// the operand through a single 1-bit arithmetic shift stage once per clock.
// Returns either the floor result (a >>> k) or the quotient truncated toward
// zero (a / 2^k), plus a flag saying whether any nonzero bit was shifted out.
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   up_valid/up_ready        request handshake; up_ready is high only in IDLE
//   up_a, up_shamt, up_trunc operand, shift amount, rounding mode (1 = toward zero)
//   down_valid/down_ready    result handshake; down_valid is high only in DONE
//   down_res, down_inexact   quotient and "remainder was nonzero" flag
module pow2_signed_divider_seq
   import pow2_div_pkg::*;
#(
   parameter int N  = 8,
   parameter int SW = shamt_width(N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          up_valid,
   output logic          up_ready,
   input  logic [N-1:0]  up_a,
   input  logic [SW-1:0] up_shamt,
   input  logic          up_trunc,
   output logic          down_valid,
   input  logic          down_ready,
   output logic [N-1:0]  down_res,
   output logic          down_inexact
);

   state_t        state;
   state_t        next_state;
   logic [N-1:0]  acc;
   logic [SW-1:0] count;
   logic          mode;
   logic          sticky;
   logic [N-1:0]  acc_shifted;
   logic          acc_lsb;
   logic          load;
   logic          step;
   logic          finish;
   logic          correction;

   sra_by_one #(.N(N)) u_sra (
      .din         (acc),
      .dout        (acc_shifted),
      .shifted_out (acc_lsb)
   );

   // Truncation toward zero differs from floor only for a negative value
   // that lost nonzero bits; bumping by one there cannot overflow because
   // the floor result of a negative operand with a remainder is at most -1.
   assign correction = mode & acc[N-1] & sticky;

   // State register. Reset drops any in-flight operation without output.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state and handshake decode. Requests are taken only in IDLE, and
   // DONE always returns to IDLE first, so there is never an accept in the
   // same cycle a result is consumed.
   always_comb begin
      next_state = state;
      up_ready   = 1'b0;
      down_valid = 1'b0;
      load       = 1'b0;
      step       = 1'b0;
      finish     = 1'b0;
      case (state)
         IDLE: begin
            up_ready = 1'b1;
            if (up_valid) begin
               load       = 1'b1;
               next_state = SHIFT;
            end
         end
         SHIFT: begin
            if (count != '0) begin
               step = 1'b1;
            end else begin
               finish     = 1'b1;
               next_state = DONE;
            end
         end
         DONE: begin
            down_valid = 1'b1;
            if (down_ready) begin
               next_state = IDLE;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Datapath: latch the request, shift one bit per cycle while collecting
   // the sticky remainder bit, then register the (possibly corrected) result.
   // The result registers are only written on finish, so they hold steady
   // for as long as the consumer stalls in DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc          <= '0;
         count        <= '0;
         mode         <= 1'b0;
         sticky       <= 1'b0;
         down_res     <= '0;
         down_inexact <= 1'b0;
      end else begin
         if (load) begin
            acc    <= up_a;
            count  <= up_shamt;
            mode   <= up_trunc;
            sticky <= 1'b0;
         end else if (step) begin
            acc    <= acc_shifted;
            sticky <= sticky | acc_lsb;
            count  <= count - 1'b1;
         end
         if (finish) begin
            down_res     <= acc + {{(N-1){1'b0}}, correction};
            down_inexact <= sticky;
         end
      end
   end

endmodule

// File: doc/pow2_signed_divider_seq.md
Name: pow2_signed_divider_seq

Overview:
- Sequential signed divide-by-power-of-2 unit with valid/ready handshakes on both sides.
- Accepts an N-bit two's-complement operand and a runtime shift amount.
- Performs one arithmetic right shift per clock using a single 1-bit shift stage.
- Returns either the floor result (plain arithmetic shift) or the quotient truncated toward zero (true signed division).
- Sits in front of the shared single-step shifter datapath and sequences it. It replaces a wide barrel shifter where area matters more than latency.

Parameters:
- N, 8, operand/result width in bits (N >= 2).
- SW, $clog2(N), width of the shift-amount field; legal shift 0..N-1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- up_valid  input  1  operand request valid.
- up_ready  output  1  block can accept a request.
- up_a  input  N  signed dividend.
- up_shamt  input  SW  power of two k; divisor = 2^k.
- up_trunc  input  1  0: floor (a >>> k); 1: truncate toward zero (a / 2^k).
- down_valid  output  1  result valid.
- down_ready  input  1  consumer accepts result.
- down_res  output  N  signed quotient.
- down_inexact  output  1  at least one nonzero bit was shifted out (remainder != 0).

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state IDLE, up_ready=1, down_valid=0, down_res=0, down_inexact=0, count=0, sticky=0.
- Reset has priority over every event, including mid-SHIFT and mid-DONE. The in-flight operation is discarded with no output.
- FSM states: IDLE, SHIFT, DONE. up_ready = (state==IDLE); down_valid = (state==DONE).
- IDLE:
  - On up_valid && up_ready, latch acc<=up_a, count<=up_shamt, mode<=up_trunc, sticky<=0, and go to SHIFT.
  - up_* inputs are sampled only on the handshake edge.
- SHIFT with count!=0, per edge:
  - acc <= {acc[N-1], acc[N-1:1]}, via the sub-module.
  - sticky <= sticky | acc[0].
  - count <= count-1.
- SHIFT with count==0, on the next edge:
  - down_res <= acc + (mode & acc[N-1] & sticky).
  - down_inexact <= sticky.
  - Go to DONE.
- Latency: down_valid rises on the (k+1)-th rising edge after the accept edge. For k=0 that is 1 edge, and the operand passes through unchanged.
- DONE:
  - down_res and down_inexact are held stable while down_valid && !down_ready.
  - On down_ready, go to IDLE.
  - No accept in the same cycle, so sustained throughput is one result per k+3 cycles.
- Arithmetic rules:
  - The truncation correction (+1) applies only to negative operands with a nonzero remainder, and never overflows.
  - For a = most-negative value with k = N-1, the result is -1 in both modes.
- The sign bit is replicated on every step, so repeated shifts of a negative value converge to all-ones (floor mode).
- up_valid asserted while not IDLE is ignored and not queued. The requester holds up_valid until up_ready.

Decomposition:
- Package pow2_div_pkg holds:
  - typedef enum logic [1:0] state_t {IDLE, SHIFT, DONE}.
  - The localparam SW computation helper.
- One sub-module: sra_by_one (combinational, N-bit, sign-replicating 1-bit right shift). The controller instantiates it once, on acc.

Test Plan:
- N=8, a=8'hE9 (-23), k=2, trunc=0 -> down_res=8'hFA (-6), down_inexact=1, down_valid 3 edges after accept. Same with trunc=1 -> 8'hFB (-5).
- a=8'h80, k=7, trunc=1 -> 8'hFF (-1), inexact=0. a=8'h81, k=7, trunc=1 -> 8'h00, inexact=1; trunc=0 -> 8'hFF.
- a=8'h7F, k=3, both modes -> 8'h0F, inexact=1. a=8'h5A, k=0 -> 8'h5A, inexact=0, down_valid 1 edge after accept, up_ready=0 until consumed.
- Backpressure:
  - Stimulus: hold down_ready=0 for 5 cycles in DONE; pulse up_valid with a different operand in that window.
  - Required: down_res is stable, up_ready=0, the new request is not accepted, and no second result appears.
- Reset mid-operation:
  - Stimulus: assert rst for 1 cycle during SHIFT of a=8'hC0, k=5.
  - Required: next cycle IDLE, up_ready=1, down_valid=0, down_res=0.
  - Then a=8'hC0, k=5, trunc=0 -> 8'hFE (-2).
- Randomized back-to-back: 1000 random (a, k, trunc) against reference models a>>>k and $signed(a)/2**k, with random down_ready stalls -> exact match, one result per accepted request, in order.
